// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX->MEM bus, aligns and extends load
// data from the synchronous data SRAM, and holds that data stable across stalls.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 80,
  parameter int MEM_TO_WB_WD = 70,
  parameter int MEM_TO_RF_WD = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic                    first;
  logic                    hold_vld;
  logic [31:0]             rdata_hold;

  logic [3:0]  sel;
  logic [31:0] pc;
  logic        ram_en;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [1:0]  off;
  logic [31:0] rd;
  logic [7:0]  byte_field;
  logic [15:0] half_field;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        unused_bits;

  // The SRAM only presents read data for one cycle, so the first held cycle of an
  // instruction captures it; every later held cycle reuses the captured copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r      <= '0;
      first      <= 1'b1;
      hold_vld   <= 1'b0;
      rdata_hold <= '0;
    end else if (!stall[3]) begin
      bus_r    <= ex_to_mem_bus;
      first    <= 1'b1;
      hold_vld <= 1'b0;
    end else if (!stall[4]) begin
      bus_r    <= '0;
      first    <= 1'b1;
      hold_vld <= 1'b0;
    end else begin
      first <= 1'b0;
      if (first) begin
        rdata_hold <= data_sram_rdata;
        hold_vld   <= 1'b1;
      end
    end
  end

  assign sel        = bus_r[79:76];
  assign pc         = bus_r[75:44];
  assign ram_en     = bus_r[43];
  assign sel_rf_res = bus_r[38];
  assign rf_we      = bus_r[37];
  assign rf_waddr   = bus_r[36:32];
  assign ex_result  = bus_r[31:0];
  assign off        = ex_result[1:0];
  assign rd         = hold_vld ? rdata_hold : data_sram_rdata;

  // Misaligned accesses are not trapped here; the low address bits pick the lane as-is.
  always_comb begin
    byte_field = rd[8*off +: 8];
    half_field = off[1] ? rd[31:16] : rd[15:0];
    load_data  = rd;
    if (sel[2]) begin
      load_data = {{24{byte_field[7] & ~sel[3]}}, byte_field};
    end else if (sel[1]) begin
      load_data = {{16{half_field[15] & ~sel[3]}}, half_field};
    end
  end

  assign rf_wdata      = (sel_rf_res & ram_en) ? load_data : ex_result;
  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};

  assign unused_bits = ^{bus_r[42:39], sel[0], stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a cycle-level behavioural model predicts both output
// buses every cycle, and directed loads, stalls, bubbles and resets pin that model.
module tb_mem_stage;

  localparam logic [5:0] S_RUN  = 6'b000000;
  localparam logic [5:0] S_HOLD = 6'b011000;
  localparam logic [5:0] S_BUB  = 6'b001000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [79:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;

  int vectors = 0;
  int miscompares = 0;

  // Model: the instruction sitting in the stage, how many edges it has been held,
  // and the SRAM data it saw in its first cycle.
  logic [79:0] m_bus;
  int          m_age;
  logic [31:0] m_first_rd;
  bit          m_valid = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus)
  );

  always @(posedge clk) begin
    if (rst) begin
      m_bus   = '0;
      m_age   = 0;
      m_valid = 1;
    end else if (!stall[3]) begin
      m_bus = ex_to_mem_bus;
      m_age = 0;
    end else if (!stall[4]) begin
      m_bus = '0;
      m_age = 0;
    end else begin
      if (m_age == 0) m_first_rd = data_sram_rdata;
      m_age = m_age + 1;
    end
  end

  function automatic logic [79:0] mk(input logic [3:0] sel, input logic [31:0] pc,
                                     input logic ram_en, input logic [3:0] be,
                                     input logic sel_rf, input logic we,
                                     input logic [4:0] waddr, input logic [31:0] ex);
    return {sel, pc, ram_en, be, sel_rf, we, waddr, ex};
  endfunction

  function automatic logic [31:0] model_wdata(input logic [79:0] b, input logic [31:0] rd);
    logic [31:0] addr;
    logic [31:0] f;
    int          off;
    addr = b[31:0];
    off  = int'(addr[1:0]);
    if (!(b[38] && b[43])) return addr;
    if (b[78]) begin
      f = (rd >> (8 * off)) & 32'hFF;
      if (!b[79] && f[7]) f = f | 32'hFFFF_FF00;
    end else if (b[77]) begin
      f = (off >= 2) ? (rd >> 16) : rd;
      f = f & 32'hFFFF;
      if (!b[79] && f[15]) f = f | 32'hFFFF_0000;
    end else begin
      f = rd;
    end
    return f;
  endfunction

  task automatic check_output(input string name, input logic [69:0] act, input logic [69:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, then compares both buses against the model.
  task automatic apply_stimulus(input logic r, input logic [5:0] s,
                                input logic [79:0] b, input logic [31:0] rdv);
    logic [31:0] rd;
    logic [31:0] wd;
    @(negedge clk);
    rst             = r;
    stall           = s;
    ex_to_mem_bus   = b;
    data_sram_rdata = rdv;
    #1;
    if (m_valid) begin
      rd = (m_age > 0) ? m_first_rd : data_sram_rdata;
      wd = model_wdata(m_bus, rd);
      check_output("model_wb", mem_to_wb_bus, {m_bus[75:44], m_bus[37], m_bus[36:32], wd});
      check_output("model_rf", {32'b0, mem_to_rf_bus}, {32'b0, m_bus[37], m_bus[36:32], wd});
    end
  endtask

  initial begin
    logic [79:0] ld_b, ld_bu, ld_h, ld_hu, ld_w, ld_w2, ld_w3, alu;
    logic [3:0]  rsel;
    rst = 1'b1; stall = S_RUN; ex_to_mem_bus = '0; data_sram_rdata = '0;

    ld_b  = mk(4'b0100, 32'h100, 1, 4'h1, 1, 1, 5'd7,  32'h1003);
    ld_bu = mk(4'b1100, 32'h104, 1, 4'h1, 1, 1, 5'd8,  32'h1003);
    ld_h  = mk(4'b0010, 32'h108, 1, 4'h3, 1, 1, 5'd9,  32'h2002);
    ld_hu = mk(4'b1010, 32'h10C, 1, 4'h3, 1, 1, 5'd10, 32'h2002);
    ld_w  = mk(4'b0001, 32'h110, 1, 4'hF, 1, 1, 5'd11, 32'h3000);
    ld_w2 = mk(4'b0001, 32'h114, 1, 4'hF, 1, 1, 5'd12, 32'h4000);
    ld_w3 = mk(4'b0001, 32'h118, 1, 4'hF, 1, 1, 5'd13, 32'h6000);
    alu   = mk(4'b0001, 32'h500, 0, 4'h0, 0, 1, 5'd3,  32'h1234_5678);

    apply_stimulus(1, S_RUN, '0, $urandom);
    apply_stimulus(1, S_RUN, '0, $urandom);
    apply_stimulus(0, S_HOLD, '0, 32'hFFFF_FFFF);
    check_output("reset_wb", mem_to_wb_bus, 70'd0);
    check_output("reset_rf", {32'b0, mem_to_rf_bus}, 70'd0);

    apply_stimulus(0, S_RUN, ld_b, 32'h0);
    apply_stimulus(0, S_RUN, ld_bu, 32'h80FF_1234);
    check_output("lb_sext", {32'b0, mem_to_rf_bus}, {32'b0, 1'b1, 5'd7, 32'hFFFF_FF80});
    apply_stimulus(0, S_RUN, ld_h, 32'h80FF_1234);
    check_output("lbu_zext", {38'b0, mem_to_rf_bus[31:0]}, {38'b0, 32'h0000_0080});
    apply_stimulus(0, S_RUN, ld_hu, 32'h8001_7FFF);
    check_output("lh_sext", {38'b0, mem_to_rf_bus[31:0]}, {38'b0, 32'hFFFF_8001});
    apply_stimulus(0, S_RUN, ld_w, 32'h8001_7FFF);
    check_output("lhu_zext", {38'b0, mem_to_rf_bus[31:0]}, {38'b0, 32'h0000_8001});

    apply_stimulus(0, S_HOLD, ld_b, 32'hDEAD_BEEF);
    check_output("hold_c0", {38'b0, mem_to_rf_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
    apply_stimulus(0, S_HOLD, ld_b, 32'h1111_1111);
    check_output("hold_c1", {38'b0, mem_to_rf_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
    apply_stimulus(0, S_HOLD, ld_b, 32'h1111_1111);
    check_output("hold_c2", {38'b0, mem_to_rf_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
    apply_stimulus(0, S_RUN, ld_w2, 32'h1111_1111);
    check_output("hold_c3", {38'b0, mem_to_rf_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
    apply_stimulus(0, S_BUB, ld_b, 32'h55AA_55AA);
    check_output("live_after_hold", {32'b0, mem_to_rf_bus}, {32'b0, 1'b1, 5'd12, 32'h55AA_55AA});

    apply_stimulus(0, S_RUN, alu, 32'h0);
    check_output("bubble_wb", mem_to_wb_bus, 70'd0);
    check_output("bubble_rf", {32'b0, mem_to_rf_bus}, 70'd0);
    apply_stimulus(0, S_RUN, ld_w3, 32'hFFFF_0000);
    check_output("alu_pass", {32'b0, mem_to_rf_bus}, {32'b0, 1'b1, 5'd3, 32'h1234_5678});
    apply_stimulus(0, S_HOLD, '0, 32'hCAFE_F00D);
    check_output("lw_live", {38'b0, mem_to_rf_bus[31:0]}, {38'b0, 32'hCAFE_F00D});
    apply_stimulus(1, S_HOLD, '0, 32'h0);
    check_output("lw_held", {38'b0, mem_to_rf_bus[31:0]}, {38'b0, 32'hCAFE_F00D});
    check_output("hold_vld_set", {69'b0, dut.hold_vld}, 70'd1);
    apply_stimulus(0, S_HOLD, '0, 32'hABCD_EF01);
    check_output("rst_stall_wb", mem_to_wb_bus, 70'd0);
    check_output("rst_stall_rf", {32'b0, mem_to_rf_bus}, 70'd0);
    check_output("rst_hold_vld", {69'b0, dut.hold_vld}, 70'd0);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] s;
      logic [1:0] kind;
      s    = 6'($urandom);
      s[3] = ($urandom_range(0, 2) == 0);
      kind = 2'($urandom_range(0, 2));
      rsel = {1'($urandom), kind == 2, kind == 1, kind == 0};
      apply_stimulus(($urandom_range(0, 63) == 0), s,
                     mk(rsel, $urandom, 1'($urandom), 4'($urandom), 1'($urandom),
                        1'($urandom), 5'($urandom), $urandom),
                     $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
